// File: rtl/epp_regfile.sv
// rtl/epp_regfile.sv - EPP host slave with parameter registers, command pulses and status byte
// Optional feature macro: EPP_AUTOINC_EN (address auto-increment on register data accesses).
// Ports:
//   clk, rst_n                 system clock, asynchronous active-low reset
//   EppAstb, EppDstb, EppWR    EPP strobes and direction (asynchronous to clk)
//   EppWait                    handshake acknowledge to host
//   EppDB_i, EppDB_o, EppDB_oe EPP data bus in / out / output enable
//   regs_flat                  register bank, register i at [8i+7:8i]
//   cmd_pulse, cmd_data        per-channel one-cycle start pulse and its data byte
//   busy                       per-channel engine busy
module epp_regfile #(
   parameter int NUM_REGS    = 16,
   parameter int NUM_CMDS    = 4,
   parameter int CMD_BASE    = 16,
   parameter int STATUS_ADDR = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  EppAstb,
   input  logic                  EppDstb,
   input  logic                  EppWR,
   output logic                  EppWait,
   input  logic [7:0]            EppDB_i,
   output logic [7:0]            EppDB_o,
   output logic                  EppDB_oe,
   output logic [NUM_REGS*8-1:0] regs_flat,
   output logic [NUM_CMDS-1:0]   cmd_pulse,
   output logic [7:0]            cmd_data,
   input  logic [NUM_CMDS-1:0]   busy
);

   localparam int         AW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [7:0] NREGS_B = 8'(NUM_REGS);
   localparam logic [7:0] CBASE_B = 8'(CMD_BASE);
   localparam logic [7:0] NCMDS_B = 8'(NUM_CMDS);
   localparam logic [7:0] STAT_B  = 8'(STATUS_ADDR);
`ifdef EPP_AUTOINC_EN
   localparam logic [7:0] LAST_REG = 8'(NUM_REGS - 1);
`endif

   // The address and data phases are executed on the edge that leaves IDLE,
   // so EppWait rises 2 sync cycles + 1 register cycle after the strobe.
   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

   state_t                     state, state_n;
   logic [1:0]                 astb_s, dstb_s, wr_s;
   logic [7:0]                 db_s1, db_s2;
   logic                       astb, dstb, host_rd;
   logic [7:0]                 address;
   logic [NUM_REGS-1:0][7:0]   regs;
   logic [NUM_CMDS-1:0]        overrun, overrun_n;
   logic                       do_addr, do_data, release_acc;
   logic                       is_reg, is_cmd, is_stat, busy_hit;
   logic [7:0]                 cmd_off;
   logic [NUM_CMDS-1:0]        cmd_hot;
   logic [AW-1:0]              idx;
   logic [3:0]                 ov4, busy4;
   logic [7:0]                 rd_byte;
`ifdef EPP_AUTOINC_EN
   logic                       inc_pend;
`endif

   // Two-flop synchronisers; strobes reset to their inactive (high) level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         astb_s <= 2'b11;
         dstb_s <= 2'b11;
         wr_s   <= 2'b00;
         db_s1  <= 8'h00;
         db_s2  <= 8'h00;
      end else begin
         astb_s <= {astb_s[0], EppAstb};
         dstb_s <= {dstb_s[0], EppDstb};
         wr_s   <= {wr_s[0], EppWR};
         db_s1  <= EppDB_i;
         db_s2  <= db_s1;
      end
   end

   assign astb    = astb_s[1];
   assign dstb    = dstb_s[1];
   assign host_rd = wr_s[1];

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   // Next-state logic
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (!astb || !dstb) state_n = HOLD;
         HOLD:    if (astb && dstb)   state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Phase decode; address strobe has priority when both are low.
   always_comb begin
      do_addr     = 1'b0;
      do_data     = 1'b0;
      release_acc = 1'b0;
      case (state)
         IDLE: begin
            do_addr = !astb;
            do_data = astb && !dstb;
         end
         HOLD:    release_acc = astb && dstb;
         default: ;
      endcase
   end

   // Address decode
   assign idx     = address[AW-1:0];
   assign is_stat = (address == STAT_B);
   assign is_reg  = !is_stat && (address < NREGS_B);
   assign cmd_off = address - CBASE_B;
   assign is_cmd  = !is_stat && (address >= CBASE_B) && (cmd_off < NCMDS_B);

   always_comb begin
      cmd_hot = '0;
      for (int k = 0; k < NUM_CMDS; k++) cmd_hot[k] = is_cmd && (cmd_off == 8'(k));
   end

   assign busy_hit = |(cmd_hot & busy);

   // Status nibbles are fixed at 4 channels: pad or truncate.
   generate
      if (NUM_CMDS >= 4) begin : g_stat_trunc
         assign ov4   = overrun[3:0];
         assign busy4 = busy[3:0];
      end else begin : g_stat_pad
         assign ov4   = {{(4 - NUM_CMDS){1'b0}}, overrun};
         assign busy4 = {{(4 - NUM_CMDS){1'b0}}, busy};
      end
   endgenerate

   always_comb begin
      rd_byte = 8'h00;
      if (is_stat)     rd_byte = {ov4, busy4};
      else if (is_reg) rd_byte = regs[idx];
   end

   // Status read clears first, so an overrun raised in the same cycle survives.
   always_comb begin
      overrun_n = overrun;
      if (do_data && host_rd && is_stat)   overrun_n = '0;
      if (do_data && !host_rd && busy_hit) overrun_n = overrun_n | cmd_hot;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         address   <= 8'h00;
         regs      <= '0;
         EppWait   <= 1'b0;
         EppDB_oe  <= 1'b0;
         EppDB_o   <= 8'h00;
         cmd_pulse <= '0;
         cmd_data  <= 8'h00;
         overrun   <= '0;
`ifdef EPP_AUTOINC_EN
         inc_pend  <= 1'b0;
`endif
      end else begin
         cmd_pulse <= '0;
         overrun   <= overrun_n;
         if (do_addr) begin
            EppWait <= 1'b1;
            if (host_rd) begin
               EppDB_o  <= address;
               EppDB_oe <= 1'b1;
            end else begin
               address <= db_s2;
            end
         end
         if (do_data) begin
            EppWait <= 1'b1;
`ifdef EPP_AUTOINC_EN
            inc_pend <= is_reg;
`endif
            if (host_rd) begin
               EppDB_o  <= rd_byte;
               EppDB_oe <= 1'b1;
            end else begin
               if (is_reg) regs[idx] <= db_s2;
               if (is_cmd && !busy_hit) begin
                  cmd_pulse <= cmd_hot;
                  cmd_data  <= db_s2;
               end
            end
         end
         if (release_acc) begin
            EppWait  <= 1'b0;
            EppDB_oe <= 1'b0;
`ifdef EPP_AUTOINC_EN
            inc_pend <= 1'b0;
            if (inc_pend) address <= (address == LAST_REG) ? 8'h00 : address + 8'h01;
`endif
         end
      end
   end

   assign regs_flat = regs;

endmodule

// File: tb/tb_epp_regfile.sv
// tb/tb_epp_regfile.sv - randomized self-checking bench for epp_regfile against a register-map model
module tb_epp_regfile;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         EppAstb = 1'b1, EppDstb = 1'b1, EppWR = 1'b0;
   logic         EppWait;
   logic [7:0]   EppDB_i = 8'h00;
   logic [7:0]   EppDB_o;
   logic         EppDB_oe;
   logic [127:0] regs_flat;
   logic [3:0]   cmd_pulse;
   logic [7:0]   cmd_data;
   logic [3:0]   busy = 4'b0000;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model of the host-visible register map
   int         ref_addr;
   logic [7:0] ref_regs [16];
   logic [3:0] ref_ov;
   logic [7:0] ref_cmd_data;

   epp_regfile #(.NUM_REGS(16), .NUM_CMDS(4), .CMD_BASE(16), .STATUS_ADDR(255)) dut (
      .clk(clk), .rst_n(rst_n), .EppAstb(EppAstb), .EppDstb(EppDstb), .EppWR(EppWR),
      .EppWait(EppWait), .EppDB_i(EppDB_i), .EppDB_o(EppDB_o), .EppDB_oe(EppDB_oe),
      .regs_flat(regs_flat), .cmd_pulse(cmd_pulse), .cmd_data(cmd_data), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [127:0] ref_flat();
      logic [127:0] f;
      for (int i = 0; i < 16; i++) f[i*8 +: 8] = ref_regs[i];
      return f;
   endfunction

   task automatic model_reset();
      ref_addr = 0;
      ref_ov = 4'b0000;
      ref_cmd_data = 8'h00;
      for (int i = 0; i < 16; i++) ref_regs[i] = 8'h00;
   endtask

   task automatic model_autoinc();
`ifdef EPP_AUTOINC_EN
      if (ref_addr < 16) ref_addr = (ref_addr + 1) % 16;
`endif
   endtask

   // One EPP access. sel[1] drops Astb, sel[0] drops Dstb. During the hold
   // phase the bus data and direction are scrambled; the access must not care.
   task automatic epp_access(input logic [1:0] sel, input logic rd, input logic [7:0] d,
                             input int hold, output logic [7:0] q0, output logic [7:0] q_end,
                             output logic oe_end, output int lat_on, output int lat_off,
                             output logic [3:0] p0, output logic [3:0] p1, output int drops);
      EppWR = rd;
      EppDB_i = d;
      @(posedge clk); #1;
      if (sel[1]) EppAstb = 1'b0;
      if (sel[0]) EppDstb = 1'b0;
      lat_on = 0;
      do begin @(posedge clk); #1; lat_on++; end while (!EppWait && lat_on < 20);
      p0 = cmd_pulse;
      q0 = EppDB_o;
      @(posedge clk); #1;
      p1 = cmd_pulse;
      drops = EppWait ? 0 : 1;
      for (int i = 0; i < hold; i++) begin
         EppDB_i = 8'($urandom);
         EppWR = ~rd;
         @(posedge clk); #1;
         if (!EppWait) drops++;
      end
      q_end = EppDB_o;
      oe_end = EppDB_oe;
      EppAstb = 1'b1;
      EppDstb = 1'b1;
      lat_off = 0;
      do begin @(posedge clk); #1; lat_off++; end while (EppWait && lat_off < 20);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic check_lat(input string tag, input int lat_on, input int lat_off, input int drops);
      check({tag, "_lat_on"}, 128'(lat_on), 128'd3);
      check({tag, "_lat_off"}, 128'(lat_off), 128'd3);
      check({tag, "_wait_held"}, 128'(drops), 128'd0);
   endtask

   task automatic do_addr_write(input logic [7:0] a, input logic [1:0] sel);
      logic [7:0] q0, qe; logic oe; int lo, lf, dr; logic [3:0] p0, p1;
      ref_addr = int'(a);
      epp_access(sel, 1'b0, a, $urandom_range(0, 3), q0, qe, oe, lo, lf, p0, p1, dr);
      check_lat("aw", lo, lf, dr);
      check("aw_oe", 128'(oe), 128'd0);
      check("aw_regs", regs_flat, ref_flat());
   endtask

   task automatic do_addr_read();
      logic [7:0] q0, qe; logic oe; int lo, lf, dr; logic [3:0] p0, p1;
      epp_access(2'b10, 1'b1, 8'h00, $urandom_range(0, 3), q0, qe, oe, lo, lf, p0, p1, dr);
      check_lat("ar", lo, lf, dr);
      check("ar_data", 128'(qe), 128'(ref_addr));
      check("ar_oe", 128'(oe), 128'd1);
   endtask

   task automatic do_data_write(input logic [7:0] d, input int hold);
      logic [7:0] q0, qe; logic oe; int lo, lf, dr; logic [3:0] p0, p1;
      logic [3:0] ep;
      ep = 4'b0000;
      if (ref_addr < 16) ref_regs[ref_addr] = d;
      else if (ref_addr >= 16 && ref_addr < 20) begin
         if (busy[ref_addr-16]) ref_ov[ref_addr-16] = 1'b1;
         else begin
            ep = 4'(1 << (ref_addr - 16));
            ref_cmd_data = d;
         end
      end
      model_autoinc();
      epp_access(2'b01, 1'b0, d, hold, q0, qe, oe, lo, lf, p0, p1, dr);
      check_lat("dw", lo, lf, dr);
      check("dw_pulse", 128'(p0), 128'(ep));
      check("dw_pulse_1cyc", 128'(p1), 128'd0);
      check("dw_cmd_data", 128'(cmd_data), 128'(ref_cmd_data));
      check("dw_oe", 128'(oe), 128'd0);
      check("dw_regs", regs_flat, ref_flat());
   endtask

   task automatic do_data_read(input int hold);
      logic [7:0] q0, qe; logic oe; int lo, lf, dr; logic [3:0] p0, p1;
      logic [7:0] exp;
      exp = 8'h00;
      if (ref_addr < 16) exp = ref_regs[ref_addr];
      else if (ref_addr == 255) begin
         exp = {ref_ov, busy};
         ref_ov = 4'b0000;
      end
      model_autoinc();
      epp_access(2'b01, 1'b1, 8'h00, hold, q0, qe, oe, lo, lf, p0, p1, dr);
      check_lat("dr", lo, lf, dr);
      check("dr_data", 128'(q0), 128'(exp));
      check("dr_data_stable", 128'(qe), 128'(exp));
      check("dr_oe", 128'(oe), 128'd1);
   endtask

   initial begin
      int n;
      logic [7:0] a;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_wait", 128'(EppWait), 128'd0);
      check("rst_oe", 128'(EppDB_oe), 128'd0);
      check("rst_dbo", 128'(EppDB_o), 128'd0);
      check("rst_pulse", 128'(cmd_pulse), 128'd0);
      check("rst_cmd_data", 128'(cmd_data), 128'd0);
      check("rst_regs", regs_flat, 128'd0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Register write / readback
      do_addr_write(8'h03, 2'b10);
      do_data_write(8'hA5, 0);
      check("reg3_a5", 128'(regs_flat[31:24]), 128'hA5);
      do_addr_write(8'h03, 2'b10);
      do_data_read(0);
      do_addr_read();

      // Command pulse, then busy overrun and status clear-on-read
      busy = 4'b0000;
      do_addr_write(8'd17, 2'b10);
      do_data_write(8'h01, 0);
      check("cmd_data_01", 128'(cmd_data), 128'h01);
      busy = 4'b0010;
      do_addr_write(8'd17, 2'b10);
      do_data_write(8'h7E, 0);
      do_addr_write(8'hFF, 2'b10);
      do_data_read(0);
      do_data_read(0);
      busy = 4'b0000;

      // Long strobe: one write only, EppWait held throughout
      do_addr_write(8'h05, 2'b10);
      do_data_write(8'h5A, 50);
      do_addr_write(8'h05, 2'b10);
      do_data_read(2);

      // Both strobes low together: address phase wins
      do_addr_write(8'h07, 2'b11);
      do_data_read(1);

`ifdef EPP_AUTOINC_EN
      do_addr_write(8'h0F, 2'b10);
      do_data_write(8'h11, 0);
      do_data_write(8'h22, 0);
      check("autoinc_reg15", 128'(regs_flat[127:120]), 128'h11);
      check("autoinc_reg0", 128'(regs_flat[7:0]), 128'h22);
`endif

      // Randomized mix of accesses against the model
      for (int it = 0; it < 60; it++) begin
         busy = 4'($urandom_range(0, 15));
         case ($urandom_range(0, 9))
            0, 1, 2: begin
               case ($urandom_range(0, 5))
                  0, 1, 2: a = 8'($urandom_range(0, 15));
                  3:       a = 8'(16 + $urandom_range(0, 3));
                  4:       a = 8'hFF;
                  default: a = 8'($urandom_range(0, 255));
               endcase
               do_addr_write(a, 2'b10);
            end
            3, 4, 5: do_data_write(8'($urandom), $urandom_range(0, 3));
            6, 7, 8: do_data_read($urandom_range(0, 3));
            default: do_addr_read();
         endcase
      end
      busy = 4'b0000;

      // Reset while an access is holding
      do_addr_write(8'h02, 2'b10);
      EppWR = 1'b1;
      @(posedge clk); #1;
      EppDstb = 1'b0;
      n = 0;
      while (!EppWait && n < 20) begin @(posedge clk); #1; n++; end
      check("hold_before_rst", 128'(EppWait), 128'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_hold_wait", 128'(EppWait), 128'd0);
      check("rst_hold_oe", 128'(EppDB_oe), 128'd0);
      check("rst_hold_regs", regs_flat, 128'd0);
      EppDstb = 1'b1;
      EppWR = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      do_addr_read();
      do_data_read(0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
